ifetch_wb_master: RTL and testbench
===================================

Name: ifetch_wb_master

Overview:
- Instruction fetch initiator for the RV32I core. It drives Wishbone B4 classic read cycles to the instruction memory slave, either directly or through the NoC adapter.
- It keeps the PC and presents one instruction at a time to decode over a valid/ready handshake.
- It handles branch/jump redirects, bus errors and unresponsive slaves.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, number of REQ cycles without ack/err before the cycle is aborted as a fault. 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect_valid  input  1  load a new fetch PC (branch/jump/trap).
- redirect_pc  input  32  target PC. Bits [1:0] are ignored and treated as 00.
- inst_valid  output  1  inst_out/inst_pc/inst_fault are valid.
- inst_ready  input  1  decode accepts the instruction.
- inst_out  output  32  fetched instruction word.
- inst_pc  output  32  address of inst_out.
- inst_fault  output  1  fetch failed (wb_err_i or timeout).
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  tied 0.
- wb_adr_o  output  32  byte address, word-aligned.
- wb_sel_o  output  4  4'hF while wb_stb_o=1, else 4'h0.
- wb_dat_i  input  32  read data.
- wb_ack_i  input  1  slave acknowledge.
- wb_err_i  input  1  slave error.

Behaviour:
- **Reset (async):**
  - pc=RESET_PC, state=IDLE, discard=0, timeout counter=0.
  - All outputs 0: inst_valid, inst_out, inst_pc, inst_fault, wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o.
  - Reset asserted mid-cycle drops cyc/stb immediately; no data is delivered.
- **States:** IDLE, REQ, HOLD. All outputs are registered.
- **IDLE:**
  - cyc=stb=0.
  - Next cycle goes to REQ with wb_adr_o={pc[31:2],2'b00}.
  - A redirect in IDLE sets pc=redirect_pc first.
- **REQ:**
  - cyc=stb=1; adr and sel are held stable.
  - The counter increments each cycle.
  - On wb_ack_i with discard=0: inst_out<=wb_dat_i, inst_pc<=pc, inst_fault<=0, inst_valid<=1, go to HOLD. cyc/stb are 0 in the next cycle.
  - On wb_err_i (err has priority over ack), or when the counter reaches TIMEOUT-1 with no ack/err: inst_out<=0, inst_fault<=1, inst_valid<=1, go to HOLD. cyc/stb drop next cycle.
- **Redirect during REQ:**
  - The bus cycle is not aborted.
  - pending_pc<=redirect_pc and discard<=1; the last redirect wins.
  - When the cycle terminates (ack, err or timeout) with discard=1: the response is dropped, pc<=pending_pc, discard<=0, go to IDLE.
  - The new fetch therefore starts 2 cycles after termination, with exactly one cycle of cyc=0.
  - A redirect in the same cycle as ack/err is treated identically, and that response is dropped.
- **HOLD:**
  - inst_valid=1; outputs are stable until inst_ready.
  - On inst_ready with no redirect: pc<=pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0), inst_valid<=0, go to REQ (cyc=1 next cycle).
  - Redirect in HOLD, with or without inst_ready: inst_valid<=0, pc<=redirect_pc, go to REQ. If inst_ready was also high the handshake counts as completed; otherwise the held instruction is dropped.
- **Throughput:** with a zero-wait slave (ack in first REQ cycle) and inst_ready held high, one instruction every 2 cycles.
- **Fault:** it is non-sticky. After it is consumed, fetch continues at pc+4 unless redirected.
- **Timeout counter:** clears on entry to REQ. With TIMEOUT=0 it never fires.

Test Plan:
1. **Linear fetch:** reset, zero-wait slave returning {adr}, inst_ready=1 → wb_adr_o = 0x0, 0x4, 0x8 on cycles 1, 3, 5. inst_out=inst_pc=0x0, 0x4, 0x8 with inst_valid for one cycle each. wb_we_o=0 and wb_sel_o=4'hF during stb throughout.
2. **Backpressure and wait states:** slave acks after 3 wait cycles and inst_ready is held low for 4 cycles → adr and cyc stay stable for 4 REQ cycles. inst_out stays constant for 4 cycles and no new cycle starts until inst_ready. The next adr is +4.
3. **Redirect mid-cycle:** redirect_pc=0x104 asserted while a fetch at 0x20 is waiting on ack → the 0x20 ack is dropped with no inst_valid. cyc is 0 for one cycle, then adr=0x104, then inst_pc=0x104. Redirect coincident with ack gives the same result.
4. **Redirect in HOLD and wrap:**
   - Redirect to 0xFFFF_FFFE while an instruction is held → the held instruction is dropped, adr=0xFFFF_FFFC.
   - After that instruction is consumed, the next adr is 0x0000_0000.
5. **Error and timeout:**
   - wb_err_i at 0x40 → inst_valid=1, inst_fault=1, inst_out=0, inst_pc=0x40, and the next fetch is at 0x44.
   - A silent slave with TIMEOUT=16 → cyc drops after 16 cycles with a fault.
6. **Reset mid-operation:** assert rst_n=0 asynchronously during REQ → cyc/stb/inst_valid go to 0 immediately. After release, the first adr is RESET_PC (test with RESET_PC=0x8000_0000).

Source files
------------

// File: rtl/ifetch_wb_master.sv
// Instruction fetch initiator: issues Wishbone B4 classic reads at the PC and
// hands one instruction at a time to decode over a valid/ready handshake.
module ifetch_wb_master #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t        state, state_nx;
  logic [31:0]   pc, pc_nx;
  logic [31:0]   pending_pc, pending_pc_nx;
  logic          discard, discard_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          inst_valid_nx, inst_fault_nx;
  logic [31:0]   inst_out_nx, inst_pc_nx;
  logic          cyc_nx, stb_nx;
  logic [31:0]   adr_nx;
  logic [3:0]    sel_nx;
  logic [31:0]   redirect_aligned;
  logic          timeout_hit;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign timeout_hit      = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign wb_we_o          = 1'b0;

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    pending_pc_nx = pending_pc;
    discard_nx    = discard;
    cnt_nx        = cnt;
    inst_valid_nx = inst_valid;
    inst_fault_nx = inst_fault;
    inst_out_nx   = inst_out;
    inst_pc_nx    = inst_pc;
    cyc_nx        = wb_cyc_o;
    stb_nx        = wb_stb_o;
    adr_nx        = wb_adr_o;
    sel_nx        = wb_sel_o;
    case (state)
      IDLE: begin
        pc_nx    = redirect_valid ? redirect_aligned : pc;
        adr_nx   = pc_nx;
        cyc_nx   = 1'b1;
        stb_nx   = 1'b1;
        sel_nx   = 4'hF;
        cnt_nx   = '0;
        state_nx = REQ;
      end
      REQ: begin
        cnt_nx = cnt + CW'(1);
        if (redirect_valid) begin
          pending_pc_nx = redirect_aligned;
          discard_nx    = 1'b1;
        end
        if (wb_err_i || wb_ack_i || timeout_hit) begin
          cyc_nx = 1'b0;
          stb_nx = 1'b0;
          sel_nx = '0;
          // A redirect arriving with the termination wins over any earlier one.
          if (discard || redirect_valid) begin
            state_nx   = IDLE;
            discard_nx = 1'b0;
            pc_nx      = redirect_valid ? redirect_aligned : pending_pc;
          end else begin
            state_nx      = HOLD;
            inst_valid_nx = 1'b1;
            inst_pc_nx    = pc;
            inst_fault_nx = wb_err_i || !wb_ack_i;
            inst_out_nx   = inst_fault_nx ? '0 : wb_dat_i;
          end
        end
      end
      HOLD: begin
        if (redirect_valid || inst_ready) begin
          pc_nx         = redirect_valid ? redirect_aligned : pc + 32'd4;
          inst_valid_nx = 1'b0;
          adr_nx        = pc_nx;
          cyc_nx        = 1'b1;
          stb_nx        = 1'b1;
          sel_nx        = 4'hF;
          cnt_nx        = '0;
          state_nx      = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pending_pc <= '0;
      discard    <= 1'b0;
      cnt        <= '0;
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      pending_pc <= pending_pc_nx;
      discard    <= discard_nx;
      cnt        <= cnt_nx;
      inst_valid <= inst_valid_nx;
      inst_fault <= inst_fault_nx;
      inst_out   <= inst_out_nx;
      inst_pc    <= inst_pc_nx;
      wb_cyc_o   <= cyc_nx;
      wb_stb_o   <= stb_nx;
      wb_adr_o   <= adr_nx;
      wb_sel_o   <= sel_nx;
    end
  end

endmodule

// File: tb/tb_ifetch_wb_master.sv
// Bench for ifetch_wb_master: vector table, directed corner sequences and a
// randomized run checked against an instruction-stream reference model.
module tb_ifetch_wb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  logic        inst_valid, inst_fault, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] inst_out, inst_pc, wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        h_valid, h_fault, h_cyc, h_stb, h_we;
  logic [31:0] h_out, h_pc, h_adr;
  logic [3:0]  h_sel;

  always #5 clk = ~clk;

  ifetch_wb_master #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  ifetch_wb_master #(.RESET_PC(32'h8000_0000), .TIMEOUT(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(h_valid), .inst_ready(inst_ready), .inst_out(h_out), .inst_pc(h_pc),
    .inst_fault(h_fault), .wb_cyc_o(h_cyc), .wb_stb_o(h_stb), .wb_we_o(h_we),
    .wb_adr_o(h_adr), .wb_sel_o(h_sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model. mode 0: ack, 1: err (ack also raised), 2: silent, 3: by address.
  int          slv_mode = 0;
  bit          slv_rand = 1'b0;
  int          slv_wait = 0;
  logic [31:0] slv_xor = '0;
  int          slv_cnt = 0;
  int          cur_wait = 0;

  function automatic int slave_kind(input logic [31:0] a);
    if (slv_mode != 3) return slv_mode;
    if (a[7:2] == 6'h2d) return 2;
    if (a[7:2] == 6'h13) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      if (slave_kind(wb_adr_o) != 2 && slv_cnt >= cur_wait) begin
        wb_ack_i = 1'b1;
        wb_err_i = (slave_kind(wb_adr_o) == 1);
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
      wb_dat_i = wb_adr_o ^ slv_xor;
      slv_cnt++;
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      slv_cnt  = 0;
      cur_wait = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst.cyc", wb_cyc_o, 1'b0);
    chk1("rst.stb", wb_stb_o, 1'b0);
    chk1("rst.valid", inst_valid, 1'b0);
    chk1("rst.fault", inst_fault, 1'b0);
    chk32("rst.out", inst_out, 32'h0);
    chk32("rst.pc", inst_pc, 32'h0);
    chk32("rst.adr", wb_adr_o, 32'h0);
    chk32("rst.sel", 32'(wb_sel_o), 32'h0);
    chk1("rst.we", wb_we_o, 1'b0);
    chk1("rst_hi.bus", h_cyc | h_stb | h_we | h_valid | h_fault, 1'b0);
    chk32("rst_hi.regs", h_out | h_pc | h_adr | 32'(h_sel), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int bound, output int n);
    n = 0;
    while (!inst_valid && n < bound) begin
      tick();
      n++;
    end
    chk1({name, ".arrives"}, inst_valid, 1'b1);
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        cyc;
    logic [31:0] adr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] iout;
  } vec_t;

  vec_t        tv[11];
  int          n;
  logic        rv, rdy, fault_e;
  logic [31:0] tgt, exp_pc, prev_adr;
  logic        prev_cyc;
  int          stall, accepts;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rdy, redirect, redirect_pc | cyc, adr, valid, inst_pc, inst_out
    tv[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
    tv[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0};
    tv[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         32'h0};
    tv[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h0};
    tv[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h4};
    tv[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0,         32'h0};
    tv[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b1, 32'h8,         32'h8};
    tv[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
    tv[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    tv[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0};
    tv[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         32'h0};

    // Linear fetch, redirect in HOLD and address wrap
    slv_mode = 0; slv_rand = 1'b0; slv_wait = 0; slv_xor = '0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk1($sformatf("tab[%0d].cyc", i), wb_cyc_o, tv[i].cyc);
      chk1($sformatf("tab[%0d].stb", i), wb_stb_o, tv[i].cyc);
      chk1($sformatf("tab[%0d].we", i), wb_we_o, 1'b0);
      chk32($sformatf("tab[%0d].sel", i), 32'(wb_sel_o), tv[i].cyc ? 32'hF : 32'h0);
      chk1($sformatf("tab[%0d].valid", i), inst_valid, tv[i].iv);
      if (tv[i].cyc) chk32($sformatf("tab[%0d].adr", i), wb_adr_o, tv[i].adr);
      if (tv[i].iv) begin
        chk32($sformatf("tab[%0d].inst_pc", i), inst_pc, tv[i].ipc);
        chk32($sformatf("tab[%0d].inst_out", i), inst_out, tv[i].iout);
        chk1($sformatf("tab[%0d].fault", i), inst_fault, 1'b0);
      end
      inst_ready = tv[i].rdy;
      redirect_valid = tv[i].rv;
      redirect_pc = tv[i].rpc;
      tick();
    end
    redirect_valid = 1'b0;

    // Wait states and backpressure
    slv_wait = 3; slv_xor = 32'hCAFE_0000;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk1("bp.req_cyc", wb_cyc_o, 1'b1);
      chk32("bp.req_adr", wb_adr_o, 32'h0);
      chk1("bp.req_valid", inst_valid, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk1("bp.hold_valid", inst_valid, 1'b1);
      chk1("bp.hold_cyc", wb_cyc_o, 1'b0);
      chk32("bp.hold_out", inst_out, 32'hCAFE_0000);
      chk32("bp.hold_pc", inst_pc, 32'h0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk1("bp.next_cyc", wb_cyc_o, 1'b1);
    chk32("bp.next_adr", wb_adr_o, 32'h4);
    chk1("bp.next_valid", inst_valid, 1'b0);

    // Redirect while waiting on ack; IDLE redirect with unaligned target
    slv_wait = 3; slv_xor = 32'h1111_0000;
    do_reset();
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    tick();
    chk1("rdm.cyc", wb_cyc_o, 1'b1);
    chk32("rdm.adr", wb_adr_o, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("rdm.wait_cyc", wb_cyc_o, 1'b1);
      chk32("rdm.wait_adr", wb_adr_o, 32'h20);
      chk1("rdm.wait_valid", inst_valid, 1'b0);
      tick();
    end
    chk1("rdm.gap_cyc", wb_cyc_o, 1'b0);
    chk1("rdm.gap_valid", inst_valid, 1'b0);
    tick();
    chk1("rdm.new_cyc", wb_cyc_o, 1'b1);
    chk32("rdm.new_adr", wb_adr_o, 32'h104);
    wait_valid("rdm", 10, n);
    chk32("rdm.latency", n, 32'd4);
    chk32("rdm.inst_pc", inst_pc, 32'h104);
    chk32("rdm.inst_out", inst_out, 32'h1111_0104);

    // Redirect coincident with ack
    slv_wait = 0;
    do_reset();
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    chk32("rdc.adr", wb_adr_o, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    tick();
    redirect_valid = 1'b0;
    chk1("rdc.gap_cyc", wb_cyc_o, 1'b0);
    chk1("rdc.gap_valid", inst_valid, 1'b0);
    tick();
    chk1("rdc.new_cyc", wb_cyc_o, 1'b1);
    chk32("rdc.new_adr", wb_adr_o, 32'h104);
    tick();
    chk1("rdc.valid", inst_valid, 1'b1);
    chk32("rdc.inst_pc", inst_pc, 32'h104);

    // Bus error (ack raised together with err)
    slv_mode = 1; slv_xor = 32'h7700_0000;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk32("err.adr", wb_adr_o, 32'h40);
    tick();
    chk1("err.valid", inst_valid, 1'b1);
    chk1("err.fault", inst_fault, 1'b1);
    chk32("err.out", inst_out, 32'h0);
    chk32("err.pc", inst_pc, 32'h40);
    chk1("err.cyc", wb_cyc_o, 1'b0);
    slv_mode = 0; inst_ready = 1'b1;
    tick();
    chk32("err.next_adr", wb_adr_o, 32'h44);
    tick();
    chk1("err.next_fault", inst_fault, 1'b0);
    chk32("err.next_pc", inst_pc, 32'h44);
    chk32("err.next_out", inst_out, 32'h7700_0044);

    // Silent slave times out after 16 REQ cycles
    slv_mode = 2;
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) begin
      chk1($sformatf("to.cyc[%0d]", i), wb_cyc_o, 1'b1);
      chk1($sformatf("to.valid[%0d]", i), inst_valid, 1'b0);
      tick();
    end
    chk1("to.cyc_drop", wb_cyc_o, 1'b0);
    chk1("to.valid", inst_valid, 1'b1);
    chk1("to.fault", inst_fault, 1'b1);
    chk32("to.out", inst_out, 32'h0);
    chk32("to.pc", inst_pc, 32'h0);
    slv_mode = 0; inst_ready = 1'b1;
    tick();
    chk32("to.next_adr", wb_adr_o, 32'h4);

    // Asynchronous reset in the middle of a bus cycle
    slv_mode = 2;
    do_reset();
    tick();
    tick();
    chk1("arst.pre_cyc", wb_cyc_o, 1'b1);
    chk1("arst.pre_hi_cyc", h_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst.cyc", wb_cyc_o, 1'b0);
    chk1("arst.stb", wb_stb_o, 1'b0);
    chk1("arst.valid", inst_valid, 1'b0);
    chk1("arst.hi_cyc", h_cyc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk1("arst.hi_cyc_after", h_cyc, 1'b1);
    chk32("arst.hi_adr", h_adr, 32'h8000_0000);
    chk32("arst.adr", wb_adr_o, 32'h0);

    // Randomized run against the instruction-stream model
    slv_mode = 3; slv_rand = 1'b1; slv_xor = 32'h5EED_0000;
    do_reset();
    exp_pc = 32'h0; prev_cyc = 1'b0; prev_adr = '0; stall = 0; accepts = 0;
    for (int c = 0; c < 2000; c++) begin
      chk1("inv.we", wb_we_o, 1'b0);
      chk1("inv.stb_eq_cyc", wb_stb_o, wb_cyc_o);
      chk32("inv.sel", 32'(wb_sel_o), wb_stb_o ? 32'hF : 32'h0);
      chk1("inv.cyc_excl_valid", wb_cyc_o && inst_valid, 1'b0);
      if (wb_cyc_o) chk1("inv.align", wb_adr_o[1:0] == 2'b00, 1'b1);
      if (wb_cyc_o && prev_cyc) chk32("inv.adr_stable", wb_adr_o, prev_adr);
      prev_cyc = wb_cyc_o;
      prev_adr = wb_adr_o;

      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      else tgt = tgt & 32'hFF;

      if (inst_valid && rdy) begin
        fault_e = (slave_kind(exp_pc) != 0);
        chk32("rand.inst_pc", inst_pc, exp_pc);
        chk1("rand.fault", inst_fault, fault_e);
        chk32("rand.inst_out", inst_out, fault_e ? 32'h0 : (exp_pc ^ slv_xor));
        exp_pc = exp_pc + 32'd4;
        stall = 0;
        accepts++;
      end else begin
        stall++;
      end
      if (rv) exp_pc = tgt & 32'hFFFF_FFFC;
      if (stall > 300) begin
        chk32("rand.progress", stall, 32'd0);
        break;
      end
      redirect_valid = rv;
      redirect_pc = tgt;
      inst_ready = rdy;
      tick();
    end
    chk1("rand.accepts", accepts > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
